// File: rtl/fifo_pkg.sv
// Shared constants and types for the fifo read-side bit packer.
package fifo_pkg;
  // Cycles from a sampled pop to the bit appearing on the fifo data port.
  localparam int FIFO_RD_LAT = 1;
  // Default number of bits packed into one output word.
  localparam int DEF_WIDTH   = 8;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } state_e;
endpackage

// File: rtl/bit_shift_capture.sv
// Indexed capture of incoming fifo bits into a word, LSB first.
// Reports the capture that completes the word and clears its count there.
module bit_shift_capture #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] word_nxt_o,
  output logic             done_o
);
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] captured_q, captured_d;

  // Drop the incoming bit into the slot selected by the capture count.
  always_comb begin
    shreg_d = shreg_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (cap_en_i && (captured_q == CNT_W'(i))) shreg_d[i] = bit_i;
    end
  end

  assign done_o     = cap_en_i && (captured_q == CNT_W'(WIDTH - 1));
  // Includes the bit arriving this cycle, so the top can latch the full word.
  assign word_nxt_o = shreg_d;

  // Count captures; restart at zero on the word-completing capture.
  always_comb begin
    captured_d = captured_q;
    if (done_o)        captured_d = '0;
    else if (cap_en_i) captured_d = captured_q + CNT_W'(1);
  end

  // Capture state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q    <= '0;
      captured_q <= '0;
    end else begin
      shreg_q    <= shreg_d;
      captured_q <= captured_d;
    end
  end
endmodule

// File: rtl/fifo_bit_packer.sv
// Pops bits from a 1-bit fifo and packs them LSB first into WIDTH-bit words
// offered downstream on a valid/ready handshake.
module fifo_bit_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             busy
);
  state_e                 state_q;
  logic [CNT_W-1:0]       issued_q;
  logic [FIFO_RD_LAT-1:0] rd_pend_q;
  logic [WIDTH-1:0]       word_q;
  logic [WIDTH-1:0]       word_nxt;
  logic                   done;

  assign word_valid = (state_q == ST_HOLD);
  assign word_out   = word_q;
  // Never pop past a full word and never while a word awaits the sink;
  // held low during reset so every output reads zero.
  assign fifo_rd    = rst & ~fifo_empty & ~word_valid & (issued_q < CNT_W'(WIDTH));
  assign busy       = (issued_q != '0) & ~word_valid;

  // Track pops in flight so each returned bit is captured exactly once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_pend_q <= '0;
    else      rd_pend_q <= FIFO_RD_LAT'({rd_pend_q, fifo_rd});
  end

  bit_shift_capture #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cap (
    .clk        (clk),
    .rst        (rst),
    .cap_en_i   (rd_pend_q[FIFO_RD_LAT-1]),
    .bit_i      (fifo_dout),
    .word_nxt_o (word_nxt),
    .done_o     (done)
  );

  // Collect/hold state machine with the pop counter and output word register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_COLLECT;
      issued_q <= '0;
      word_q   <= '0;
    end else begin
      if (done)         issued_q <= '0;
      else if (fifo_rd) issued_q <= issued_q + CNT_W'(1);
      case (state_q)
        ST_COLLECT: begin
          if (done) begin
            word_q  <= word_nxt;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (word_ready) state_q <= ST_COLLECT;
        end
        default: state_q <= ST_COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_bit_packer.sv
// Directed bench for fifo_bit_packer with a behavioural 1-bit fifo model.
module tb_fifo_bit_packer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         fifo_dout = 1'b0;
  logic         fifo_empty;
  logic         fifo_rd;
  logic [W-1:0] word_out;
  logic         word_valid;
  logic         word_ready = 1'b0;
  logic         busy;

  logic mem [0:255];
  int   head = 0;
  int   tail = 0;
  int   pops = 0;
  int   errors = 0;
  int   checks = 0;

  fifo_bit_packer #(.WIDTH(W), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (head == tail);

  // Fifo model: a pop sampled at an edge presents its bit after that edge.
  always @(posedge clk) begin
    if (fifo_rd && !fifo_empty) begin
      fifo_dout <= mem[head];
      head      <= head + 1;
      pops      <= pops + 1;
    end
  end

  typedef struct {
    logic [7:0] seq;   // bit 7 is pushed first
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      mem[tail] = seq[7-i];
      tail = tail + 1;
    end
  endtask

  task automatic cyc1();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!word_valid && cyc < 100) begin
      cyc1();
      cyc++;
    end
    if (!word_valid) chk("valid_timeout", 32'(cyc), 32'd9);
  endtask

  initial begin
    vec_t tbl [6];
    int   cyc;
    int   p0;
    int   n;

    tbl[0] = '{seq: 8'b00000001, exp: 8'h80};
    tbl[1] = '{seq: 8'b11110000, exp: 8'h0F};
    tbl[2] = '{seq: 8'b01010101, exp: 8'hAA};
    tbl[3] = '{seq: 8'b10000000, exp: 8'h01};
    tbl[4] = '{seq: 8'b11100100, exp: 8'h27};
    tbl[5] = '{seq: 8'b11111111, exp: 8'hFF};

    // Reset with a non-empty fifo: nothing may be popped or shown.
    push(8'b10110011, 8);
    repeat (3) cyc1();
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_word", 32'(word_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pops", 32'(pops), 32'd0);

    // First word straight out of reset, sink always ready.
    word_ready = 1'b1;
    rst = 1'b1;
    wait_valid(cyc);
    chk("w0_latency", 32'(cyc), 32'd9);
    chk("w0_word", 32'(word_out), 32'hCD);
    chk("w0_pops", 32'(pops), 32'd8);
    chk("w0_empty_after_last_pop", 32'(fifo_empty), 32'd1);
    cyc1();
    chk("w0_pulse", 32'(word_valid), 32'd0);

    // Table of pre-filled words.
    foreach (tbl[k]) begin
      p0 = pops;
      push(tbl[k].seq, 8);
      wait_valid(cyc);
      chk($sformatf("t%0d_latency", k), 32'(cyc), 32'd9);
      chk($sformatf("t%0d_word", k), 32'(word_out), 32'(tbl[k].exp));
      chk($sformatf("t%0d_pops", k), 32'(pops - p0), 32'd8);
      cyc1();
      chk($sformatf("t%0d_pulse", k), 32'(word_valid), 32'd0);
    end

    // Backpressure: 16 bits queued, sink stalled.
    word_ready = 1'b0;
    p0 = pops;
    push(8'b11001010, 8);
    push(8'b00011110, 8);
    wait_valid(cyc);
    chk("bp_latency", 32'(cyc), 32'd9);
    chk("bp_word1", 32'(word_out), 32'h53);
    for (int i = 0; i < 5; i++) begin
      cyc1();
      chk("bp_hold_rd", 32'(fifo_rd), 32'd0);
      chk("bp_hold_valid", 32'(word_valid), 32'd1);
      chk("bp_hold_word", 32'(word_out), 32'h53);
    end
    chk("bp_pops_held", 32'(pops - p0), 32'd8);
    word_ready = 1'b1;
    cyc1();
    word_ready = 1'b0;
    chk("bp_release", 32'(word_valid), 32'd0);
    wait_valid(cyc);
    chk("bp_latency2", 32'(cyc), 32'd9);
    chk("bp_word2", 32'(word_out), 32'h78);
    chk("bp_pops_total", 32'(pops - p0), 32'd16);
    word_ready = 1'b1;
    cyc1();

    // Fifo runs dry after 3 bits, refilled 10 cycles later.
    p0 = pops;
    push(8'b10100000, 3);
    n = 0;
    for (int i = 0; i < 13; i++) begin
      cyc1();
      if (busy !== 1'b1) n++;
    end
    chk("stall_busy_drops", 32'(n), 32'd0);
    chk("stall_pops", 32'(pops - p0), 32'd3);
    chk("stall_valid", 32'(word_valid), 32'd0);
    push(8'b11001000, 5);
    wait_valid(cyc);
    chk("stall_word", 32'(word_out), 32'h9D);
    chk("stall_pops_total", 32'(pops - p0), 32'd8);
    cyc1();

    // Reset mid-word: the partial bits must be discarded.
    p0 = pops;
    push(8'b11111000, 5);
    n = 0;
    while ((pops - p0) < 5 && n < 50) begin
      cyc1();
      n++;
    end
    chk("mid_pops", 32'(pops - p0), 32'd5);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(word_valid), 32'd0);
    push(8'b00000001, 8);
    #1;
    chk("mid_rst_rd", 32'(fifo_rd), 32'd0);
    p0 = pops;
    repeat (2) cyc1();
    chk("mid_rst_no_pop", 32'(pops - p0), 32'd0);
    rst = 1'b1;
    wait_valid(cyc);
    chk("mid_fresh_latency", 32'(cyc), 32'd9);
    chk("mid_fresh_word", 32'(word_out), 32'h80);
    cyc1();
    chk("mid_fresh_pulse", 32'(word_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
